// File: rtl/e203_clk_gate_ctrl_if.sv
// Handshake bundle between the clock-gate controller and its parent:
// activity requests and core status in, per-channel gate/sleep controls out.
interface e203_clk_gate_ctrl_if #(
    parameter int NUM_CH = 6,
    parameter int HOLD_W = 4
);
    logic              core_cgstop;
    logic              core_wfi;
    logic [HOLD_W-1:0] hold_cyc;
    logic [NUM_CH-1:0] ch_active;
    logic [NUM_CH-1:0] ch_clk_en;
    logic [NUM_CH-1:0] ch_ls;
    logic [NUM_CH-1:0] ch_waking;
    logic              all_off;

    modport master (
        output core_cgstop, core_wfi, hold_cyc, ch_active,
        input  ch_clk_en, ch_ls, ch_waking, all_off
    );

    modport slave (
        input  core_cgstop, core_wfi, hold_cyc, ch_active,
        output ch_clk_en, ch_ls, ch_waking, all_off
    );
endinterface

// File: rtl/e203_clk_gate_ctrl.sv
// Multi-channel clock-enable controller: per-channel ON/HOLD/OFF/WAKE FSM with
// idle hysteresis, WFI request masking and memory light-sleep wake sequencing.
module e203_clk_gate_ctrl #(
    parameter int                 NUM_CH   = 6,
    parameter int                 HOLD_W   = 4,
    parameter int                 WAKE_CYC = 2,
    parameter logic [NUM_CH-1:0]  WFI_MASK = NUM_CH'(6'b000001),
    parameter logic [NUM_CH-1:0]  LS_MASK  = NUM_CH'(6'b110000)
) (
    input  logic                  clk,
    input  logic                  rst,
    e203_clk_gate_ctrl_if.slave   gate
);

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_HOLD = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } ch_state_e;

    localparam logic [HOLD_W-1:0] WAKE_LOAD = HOLD_W'(WAKE_CYC - 1);
    localparam logic [HOLD_W-1:0] CNT_ONE   = HOLD_W'(1);

    ch_state_e         state_q [NUM_CH];
    ch_state_e         state_d [NUM_CH];
    logic [HOLD_W-1:0] cnt_q   [NUM_CH];
    logic [HOLD_W-1:0] cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] req;
    logic              all_in_off;

    // A masked channel sees no request while the core sleeps in WFI.
    assign req = gate.ch_active & ~({NUM_CH{gate.core_wfi}} & WFI_MASK);

    // NOTE: state registers use non-blocking assignments so every channel
    // samples the same pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_ON;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // NOTE: next-state and counter default to holding their value before
    // any branch, so no path through the case leaves them unassigned (no latch).
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (gate.core_cgstop) begin
                state_d[i] = ST_ON;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_ON: begin
                        if (!req[i]) begin
                            if (gate.hold_cyc == '0) begin
                                state_d[i] = ST_OFF;
                            end else begin
                                state_d[i] = ST_HOLD;
                                cnt_d[i]   = gate.hold_cyc - CNT_ONE;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (req[i]) begin
                            state_d[i] = ST_ON;
                        end else if (cnt_q[i] == '0) begin
                            state_d[i] = ST_OFF;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                    ST_OFF: begin
                        if (req[i]) begin
                            if (LS_MASK[i]) begin
                                state_d[i] = ST_WAKE;
                                cnt_d[i]   = WAKE_LOAD;
                            end else begin
                                state_d[i] = ST_ON;
                            end
                        end
                    end
                    ST_WAKE: begin
                        // A dropped request does not abort the wake; the
                        // channel reaches ON first and then decays normally.
                        if (cnt_q[i] == '0) begin
                            state_d[i] = ST_ON;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                    default: begin
                        state_d[i] = ST_ON;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Clocks run during reset so downstream synchronous resets take effect.
    always_comb begin
        gate.ch_clk_en = '0;
        gate.ch_ls     = '0;
        gate.ch_waking = '0;
        all_in_off     = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            gate.ch_clk_en[i] = rst | gate.core_cgstop
                              | (state_q[i] == ST_ON) | (state_q[i] == ST_HOLD)
                              | ((state_q[i] == ST_OFF) & req[i] & ~LS_MASK[i]);
            gate.ch_ls[i]     = ~rst & LS_MASK[i] & (state_q[i] == ST_OFF)
                              & ~gate.core_cgstop & ~req[i];
            gate.ch_waking[i] = ~rst & (state_q[i] == ST_WAKE);
            if (state_q[i] != ST_OFF) begin
                all_in_off = 1'b0;
            end
        end
        gate.all_off = ~gate.core_cgstop & ~rst & all_in_off;
    end

endmodule

// File: tb/tb_e203_clk_gate_ctrl.sv
// Directed self-checking bench for e203_clk_gate_ctrl: reset, hysteresis,
// light-sleep wake, WFI masking, cgstop override and mid-HOLD reset.
module tb_e203_clk_gate_ctrl;

    localparam int NUM_CH = 6;
    localparam int HOLD_W = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    e203_clk_gate_ctrl_if #(.NUM_CH(NUM_CH), .HOLD_W(HOLD_W)) gate_if ();

    e203_clk_gate_ctrl #(
        .NUM_CH   (NUM_CH),
        .HOLD_W   (HOLD_W),
        .WAKE_CYC (2),
        .WFI_MASK (6'b000001),
        .LS_MASK  (6'b110000)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .gate (gate_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  t2_act, t2_en;
        logic [10:0] t2b_act, t2b_en;
        logic [5:0]  t2c_en;
        logic [4:0]  t4_wfi;
        logic [1:0]  t4_en [5];
        logic [5:0]  t3_act;
        logic [2:0]  t3_exp [6];

        rst                    = 1'b1;
        gate_if.core_cgstop    = 1'b0;
        gate_if.core_wfi       = 1'b0;
        gate_if.hold_cyc       = '0;
        gate_if.ch_active      = '0;

        // Reset and release with everything idle.
        tick();
        tick();
        #1;
        check("rst_en",     32'(gate_if.ch_clk_en), 32'h3F);
        check("rst_ls",     32'(gate_if.ch_ls),     32'h00);
        check("rst_waking", 32'(gate_if.ch_waking), 32'h00);
        check("rst_alloff", 32'(gate_if.all_off),   32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_en",     32'(gate_if.ch_clk_en), 32'h3F);
        check("post_rst_alloff", 32'(gate_if.all_off),   32'h0);
        tick();
        #1;
        check("idle_en",     32'(gate_if.ch_clk_en), 32'h00);
        check("idle_ls",     32'(gate_if.ch_ls),     32'h30);
        check("idle_alloff", 32'(gate_if.all_off),   32'h1);

        // ch0 hold_cyc=3: three active cycles, then hold_cyc+1 trailing cycles.
        gate_if.hold_cyc = 4'd3;
        t2_act = 8'b0000_0111;
        t2_en  = 8'b0111_1111;
        for (int k = 0; k < 8; k++) begin
            gate_if.ch_active[0] = t2_act[k];
            #1;
            check($sformatf("trail_en0_k%0d", k), 32'(gate_if.ch_clk_en[0]), 32'(t2_en[k]));
            tick();
        end

        // Re-assert during HOLD keeps the enable continuous.
        t2b_act = 11'b000_0010_0111;
        t2b_en  = 11'b011_1111_1111;
        for (int k = 0; k < 11; k++) begin
            gate_if.ch_active[0] = t2b_act[k];
            #1;
            check($sformatf("reassert_en0_k%0d", k), 32'(gate_if.ch_clk_en[0]), 32'(t2b_en[k]));
            tick();
        end

        // hold_cyc changed mid-HOLD must not alter the running count.
        t2c_en = 6'b01_1111;
        for (int k = 0; k < 6; k++) begin
            gate_if.hold_cyc     = (k >= 2) ? 4'd0 : 4'd3;
            gate_if.ch_active[0] = (k == 0);
            #1;
            check($sformatf("holdchg_en0_k%0d", k), 32'(gate_if.ch_clk_en[0]), 32'(t2c_en[k]));
            tick();
        end

        // ch5 light-sleep wake with WAKE_CYC=2; result bits {waking5, en5, ls5}.
        gate_if.hold_cyc = 4'd0;
        t3_act = 6'b00_1111;
        t3_exp = '{3'b000, 3'b100, 3'b100, 3'b010, 3'b010, 3'b001};
        for (int k = 0; k < 6; k++) begin
            gate_if.ch_active[5] = t3_act[k];
            #1;
            check($sformatf("wake5_k%0d", k),
                  32'({gate_if.ch_waking[5], gate_if.ch_clk_en[5], gate_if.ch_ls[5]}),
                  32'(t3_exp[k]));
            tick();
        end

        // WFI masks ch0 only; ch1 stays enabled; un-WFI re-enables ch0 at once.
        gate_if.hold_cyc  = 4'd2;
        gate_if.ch_active = 6'b000011;
        tick();
        tick();
        t4_wfi = 5'b01111;
        t4_en  = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b11};
        for (int k = 0; k < 5; k++) begin
            gate_if.core_wfi = t4_wfi[k];
            #1;
            check($sformatf("wfi_en10_k%0d", k), 32'(gate_if.ch_clk_en[1:0]), 32'(t4_en[k]));
            tick();
        end
        gate_if.ch_active = '0;
        gate_if.core_wfi  = 1'b0;
        gate_if.hold_cyc  = 4'd0;
        tick();
        tick();
        tick();
        #1;
        check("quiet_alloff", 32'(gate_if.all_off), 32'h1);
        check("quiet_ls",     32'(gate_if.ch_ls),   32'h30);

        // cgstop pulse while ch4 is in WAKE, then hysteresis with hold_cyc=1.
        gate_if.hold_cyc     = 4'd1;
        gate_if.ch_active[4] = 1'b1;
        #1;
        check("cg_c0_en4", 32'(gate_if.ch_clk_en[4]), 32'h0);
        check("cg_c0_ls4", 32'(gate_if.ch_ls[4]),     32'h0);
        tick();
        gate_if.core_cgstop  = 1'b1;
        gate_if.ch_active[4] = 1'b0;
        #1;
        check("cg_c1_en",     32'(gate_if.ch_clk_en),    32'h3F);
        check("cg_c1_ls",     32'(gate_if.ch_ls),        32'h00);
        check("cg_c1_wake4",  32'(gate_if.ch_waking[4]), 32'h1);
        check("cg_c1_alloff", 32'(gate_if.all_off),      32'h0);
        tick();
        gate_if.core_cgstop = 1'b0;
        #1;
        check("cg_c2_en",    32'(gate_if.ch_clk_en), 32'h3F);
        check("cg_c2_wake",  32'(gate_if.ch_waking), 32'h00);
        tick();
        #1;
        check("cg_c3_en", 32'(gate_if.ch_clk_en), 32'h3F);
        tick();
        #1;
        check("cg_c4_en",     32'(gate_if.ch_clk_en), 32'h00);
        check("cg_c4_ls",     32'(gate_if.ch_ls),     32'h30);
        check("cg_c4_alloff", 32'(gate_if.all_off),   32'h1);

        // Reset while ch3 sits in HOLD with cnt=2.
        gate_if.hold_cyc     = 4'd3;
        gate_if.ch_active[3] = 1'b1;
        tick();
        gate_if.ch_active[3] = 1'b0;
        tick();
        #1;
        check("hold3_en3", 32'(gate_if.ch_clk_en[3]), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_hold_en",     32'(gate_if.ch_clk_en), 32'h3F);
        check("rst_hold_alloff", 32'(gate_if.all_off),   32'h0);
        tick();
        rst              = 1'b0;
        gate_if.hold_cyc = 4'd0;
        #1;
        check("rst_rel_en", 32'(gate_if.ch_clk_en), 32'h3F);
        tick();
        #1;
        check("rst_rel_off_en",  32'(gate_if.ch_clk_en), 32'h00);
        check("rst_rel_alloff",  32'(gate_if.all_off),   32'h1);

        // cgstop with every channel OFF overrides all_off and light-sleep.
        gate_if.core_cgstop = 1'b1;
        #1;
        check("cgoff_en",     32'(gate_if.ch_clk_en), 32'h3F);
        check("cgoff_ls",     32'(gate_if.ch_ls),     32'h00);
        check("cgoff_alloff", 32'(gate_if.all_off),   32'h0);
        tick();
        gate_if.core_cgstop = 1'b0;
        #1;
        check("cgoff_on_en", 32'(gate_if.ch_clk_en), 32'h3F);
        tick();
        #1;
        check("cgoff_back_en", 32'(gate_if.ch_clk_en), 32'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/e203_clk_gate_ctrl.md
Name: e203_clk_gate_ctrl

Overview:
Parametrised, multi-channel clock-enable controller for the core and TCM clock domains. Each channel has its own FSM with:
- programmable idle hysteresis before gating,
- optional WFI masking,
- optional memory light-sleep sequencing with a wake delay.

Outputs are per-channel gate enables and light-sleep controls. The parent instantiates the e203_clkgate cells from these enables.

Parameters:
NUM_CH, 6, number of gated channels (1..16).
HOLD_W, 4, width of the hold_cyc hysteresis input and per-channel counters.
WAKE_CYC, 2, cycles that light-sleep stays deasserted before the clock is re-enabled (1..15).
WFI_MASK, 6'b000001, bit i=1: channel i request is suppressed while core_wfi=1.
LS_MASK, 6'b110000, bit i=1: channel i drives light-sleep and uses the WAKE sequence.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
core_cgstop  in  1  force all channels enabled; light-sleep off (debug override)
core_wfi  in  1  core in WFI
hold_cyc  in  HOLD_W  extra idle cycles to keep a clock running after the request drops
ch_active  in  NUM_CH  per-channel activity request
ch_clk_en  out  NUM_CH  per-channel gate enable
ch_ls  out  NUM_CH  per-channel memory light-sleep (always 0 where LS_MASK=0)
ch_waking  out  NUM_CH  1 while the channel is in WAKE
all_off  out  1  1 when every channel is in OFF and core_cgstop=0

Behaviour:
- req[i] = ch_active[i] & ~(core_wfi & WFI_MASK[i]).
- Per-channel states: ON, HOLD, OFF, WAKE. Each channel has a HOLD_W-bit counter cnt.
- Reset (rst=1, sampled on clk):
  - state <= ON, cnt <= 0.
  - While rst=1: ch_clk_en all 1, ch_ls all 0, ch_waking all 0, all_off 0. Clocks must run so downstream synchronous resets take effect.
- Outputs (combinational from state and inputs):
  - ch_clk_en[i] = core_cgstop | state∈{ON,HOLD} | (state==OFF & req[i] & ~LS_MASK[i]).
    - Non-LS channels wake with zero latency.
  - ch_ls[i] = LS_MASK[i] & (state==OFF) & ~core_cgstop & ~req[i].
    - Light-sleep drops in the same cycle a request arrives.
  - ch_waking[i] = (state==WAKE).
- Transitions, evaluated in priority order:
  - core_cgstop=1: any state -> ON, cnt <= 0.
  - ON: req -> ON. ~req & hold_cyc==0 -> OFF. ~req & hold_cyc!=0 -> HOLD, cnt <= hold_cyc-1.
  - HOLD: req -> ON. ~req & cnt==0 -> OFF. Otherwise cnt <= cnt-1.
  - OFF: req & ~LS_MASK[i] -> ON. req & LS_MASK[i] -> WAKE, cnt <= WAKE_CYC-1. ~req -> OFF.
  - WAKE: cnt==0 -> ON. Otherwise cnt <= cnt-1. req dropping during WAKE does not abort; the channel reaches ON, then decays normally.
- Trailing enable: after the last cycle with req=1, ch_clk_en stays 1 for exactly hold_cyc+1 cycles, then 0.
- Wake latency, LS channel: from the first req cycle in OFF, ch_clk_en rises WAKE_CYC+1 cycles later. ch_ls is 0 throughout.
- hold_cyc is sampled only on ON->HOLD entry. Changes during HOLD do not affect the running count.
- Counter arithmetic is unsigned HOLD_W-bit with no wrap. Decrement only when cnt!=0.
- Channels are fully independent. Simultaneous events on different channels do not interact.
- all_off = ~core_cgstop & ~rst & (all states == OFF).
- core_cgstop asserted mid-WAKE or mid-HOLD: enable is 1 in the same cycle, and state is ON the next cycle.
- core_wfi with WFI_MASK=0 has no effect.

Test Plan:
1. Reset release, all ch_active=0, hold_cyc=0: ch_clk_en=6'h3F during rst and on the first cycle after. Next cycle ch_clk_en=0, ch_ls=6'b110000, all_off=1.
2. ch0, hold_cyc=3: ch_active[0] high for cycles 10-12, low from 13 -> ch_clk_en[0]=1 for cycles 10-16 and 0 at cycle 17. Re-asserting req at 15 keeps it high continuously.
3. ch5 (LS) in OFF, WAKE_CYC=2: ch_active[5] rises at cycle 20 -> ch_ls[5]=0 at 20. ch_waking[5]=1 at 21-22. ch_clk_en[5]=1 from 23.
4. ch0 active, core_wfi=1 -> ch_clk_en[0] falls after the hold window. ch1 active with core_wfi=1 stays enabled. Deasserting core_wfi -> ch_clk_en[0]=1 in the same cycle.
5. core_cgstop pulsed for 1 cycle while ch4 is in WAKE -> all ch_clk_en=1 and ch_ls=0 that cycle. ch4 is in ON next cycle, then follows normal hysteresis.
6. rst asserted while ch3 is in HOLD with cnt=2 -> next cycle state ON, cnt=0, all enables 1. After rst drops with req=0 and hold_cyc=0, ch3 reaches OFF after 1 trailing cycle.
